// File: rtl/regfile_pkg.sv
// Shared default sizes and word/address types for the general-purpose register file.
package regfile_pkg;

    localparam int REG_WIDTH_DEFAULT = 16;
    localparam int REG_DEPTH_DEFAULT = 8;

    typedef logic [REG_WIDTH_DEFAULT-1:0]         reg_word_t;
    typedef logic [$clog2(REG_DEPTH_DEFAULT)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one busy bit per register, a running busy count and a double-reserve error pulse.
// Reserve sets a bit, writeback clears it; reserve wins when both target the same register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = REG_DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DEPTH-1:0]  busy,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              err_dbl_rsv
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;
    logic [ADDR_W:0]  r_busy_cnt;
    logic             r_err_dbl_rsv;
    logic             w_same;
    logic             w_inc;
    logic             w_dec;
    logic             w_dbl;

    // A same-address write+reserve leaves the bit set, so it neither releases nor double-reserves.
    assign w_same = we && rsv && (wr_addr == rsv_addr);
    assign w_inc  = rsv && !r_busy[rsv_addr];
    assign w_dec  = we && r_busy[wr_addr] && !w_same;
    assign w_dbl  = rsv && r_busy[rsv_addr] && !w_same;

    always_comb begin
        // NOTE: the default assignment covers every path, so no latch is inferred.
        w_busy_next = r_busy;
        if (we)  w_busy_next[wr_addr]  = 1'b0;
        if (rsv) w_busy_next[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy        <= '0;
            r_busy_cnt    <= '0;
            r_err_dbl_rsv <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, like real hardware.
            r_busy        <= w_busy_next;
            r_busy_cnt    <= r_busy_cnt + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
            r_err_dbl_rsv <= w_dbl;
        end
    end

    assign busy        = r_busy;
    assign busy_cnt    = r_busy_cnt;
    assign err_dbl_rsv = r_err_dbl_rsv;

endmodule

// File: rtl/gp_regfile_sb.sv
// Parametrised register file: one write port, NUM_RD combinational read ports, busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy state onto matching read ports.
module gp_regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH_DEFAULT,
    parameter int DEPTH  = REG_DEPTH_DEFAULT,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rsv,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          busy_cnt,
    output logic                     any_busy,
    output logic                     err_dbl_rsv
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] w_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every register must clear on reset, so this array is built from flops, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .wr_addr     (wr_addr),
        .rsv         (rsv),
        .rsv_addr    (rsv_addr),
        .busy        (w_busy),
        .busy_cnt    (busy_cnt),
        .err_dbl_rsv (err_dbl_rsv)
    );

    assign any_busy = (busy_cnt != '0);

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        logic w_hit;
        assign w_hit                     = we && (w_ra == wr_addr);
        assign rd_data[k*WIDTH +: WIDTH] = w_hit ? wr_data : r_mem[w_ra];
        assign rd_busy[k]                = w_hit ? (rsv && (rsv_addr == wr_addr)) : w_busy[w_ra];
`else
        assign rd_data[k*WIDTH +: WIDTH] = r_mem[w_ra];
        assign rd_busy[k]                = w_busy[w_ra];
`endif
    end

endmodule
